// File: rtl/arm_pkg.sv
// Shared definitions for the memory stage: data width, SRAM base mapping,
// memory-stage state encoding and the load/store op type that the control
// unit and the EX/MEM register also use.
package arm_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam logic [31:0] BASE_ADDR = 32'd1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        MEM_NONE = 2'd0,
        MEM_RD   = 2'd1,
        MEM_WR   = 2'd2
    } mem_op_t;

    // Store has priority when decode raises both enables.
    function automatic mem_op_t decode_op(input logic r_en, input logic w_en);
        if (w_en) begin
            return MEM_WR;
        end
        if (r_en) begin
            return MEM_RD;
        end
        return MEM_NONE;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter with a zero flag. Stops at zero; load has priority
// over decrement. Generic enough for other multi-cycle units.
module mem_wait_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count;

    // Count register: load, else decrement while non-zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_stage_responder.sv
// Memory-stage responder: takes one LDR/STR word request from EX/MEM, runs a
// fixed wait-state access on the external SRAM and holds ready low / freeze
// high until the access has completed.
// Optional feature: define MEM_READ_BYPASS_EN to add a single-entry buffer of
// the last completed read, giving 1-cycle hits without touching the SRAM.
module mem_stage_responder #(
    parameter int unsigned DATA_W      = arm_pkg::DATA_W,
    parameter int unsigned SRAM_AW     = 17,
    parameter logic [31:0] BASE_ADDR   = arm_pkg::BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        address,
    input  logic [DATA_W-1:0]  wr_data,
    output logic [DATA_W-1:0]  rd_data,
    output logic               ready,
    output logic               freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [DATA_W-1:0]  sram_wdata,
    input  logic [DATA_W-1:0]  sram_rdata,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    import arm_pkg::*;

    localparam int unsigned     CNT_W     = 4;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    mem_state_t         state;
    mem_state_t         state_next;
    mem_op_t            op_q;
    mem_op_t            req_op;
    logic               req;
    logic [SRAM_AW-1:0] req_word;
    logic [SRAM_AW-1:0] addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rd_data_q;
    logic               cnt_load;
    logic               cnt_dec;
    logic               cnt_zero;
    logic               byp_hit;
    logic               access_last;

    assign req      = mem_r_en | mem_w_en;
    assign req_op   = decode_op(mem_r_en, mem_w_en);
    // Byte-to-word mapping; wraps modulo 2^32 and aliases out-of-range addresses.
    assign req_word = SRAM_AW'((address - BASE_ADDR) >> 2);

    assign cnt_load    = (state == IDLE) && req;
    assign cnt_dec     = (state == ACCESS);
    assign access_last = (state == ACCESS) && cnt_zero;

    mem_wait_counter #(
        .CNT_W (CNT_W)
    ) u_wait_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt_load),
        .load_value (WAIT_LOAD),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

`ifdef MEM_READ_BYPASS_EN
    logic               byp_valid;
    logic [SRAM_AW-1:0] byp_word;
    logic [DATA_W-1:0]  byp_data;

    assign byp_hit = byp_valid && (byp_word == req_word);

    // Read buffer: refilled by every completed read, kept coherent by writes to the same word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_valid <= 1'b0;
            byp_word  <= '0;
            byp_data  <= '0;
        end else if (access_last) begin
            if (op_q == MEM_RD) begin
                byp_valid <= 1'b1;
                byp_word  <= addr_q;
                byp_data  <= sram_rdata;
            end else if ((op_q == MEM_WR) && (byp_word == addr_q)) begin
                byp_data  <= wdata_q;
            end
        end
    end
`else
    assign byp_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a buffer hit skips the SRAM phase entirely.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = ((req_op == MEM_RD) && byp_hit) ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_zero) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch: captured only when a request is accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= MEM_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (cnt_load) begin
            op_q    <= req_op;
            addr_q  <= req_word;
            wdata_q <= wr_data;
        end
    end

    // Load result: captured on the last ACCESS cycle (or from the buffer on a hit).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (access_last && (op_q == MEM_RD)) begin
            rd_data_q <= sram_rdata;
`ifdef MEM_READ_BYPASS_EN
        end else if ((state == IDLE) && (req_op == MEM_RD) && byp_hit) begin
            rd_data_q <= byp_data;
`endif
        end
    end

    // Outputs: handshake and SRAM strobes decoded from state and latched op.
    always_comb begin
        ready     = 1'b0;
        sram_we_n = 1'b1;
        sram_oe_n = 1'b1;
        case (state)
            IDLE:   ready = ~req;
            ACCESS: begin
                sram_we_n = ~(op_q == MEM_WR);
                sram_oe_n = ~(op_q == MEM_RD);
            end
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign freeze     = ~ready;
    assign rd_data    = rd_data_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage_responder.sv
// Bench for mem_stage_responder: transaction-level reference model with an
// every-cycle compare process, an SRAM device model, directed scenarios with
// literal expectations and a randomized request stream.
module tb_mem_stage_responder;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 17;
    localparam int unsigned WC   = 4;
    localparam logic [31:0] BASE = 32'd1024;
`ifdef MEM_READ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int HIT_LAT = BYP ? 1 : WC + 1;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          mem_r_en = 1'b0;
    logic          mem_w_en = 1'b0;
    logic [31:0]   address  = '0;
    logic [DW-1:0] wr_data  = '0;
    logic [DW-1:0] rd_data;
    logic          ready;
    logic          freeze;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic          sram_we_n;
    logic          sram_oe_n;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mem_stage_responder #(
        .DATA_W      (DW),
        .SRAM_AW     (AW),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .address    (address),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .ready      (ready),
        .freeze     (freeze),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Contents of never-written SRAM words.
    function automatic logic [31:0] init_pat(input logic [AW-1:0] w);
        return 32'hA5C3_0000 ^ 32'(w) ^ (32'(w) << 13);
    endfunction

    function automatic logic [AW-1:0] word_of(input logic [31:0] a);
        return AW'((a - BASE) >> 2);
    endfunction

    // SRAM device: acts on strobes mid-cycle, counts strobe cycles.
    logic [31:0]   dev_mem [logic [AW-1:0]];
    int            we_cnt    = 0;
    int            oe_cnt    = 0;
    logic [AW-1:0] last_addr = '0;

    initial begin : sram_dev
        sram_rdata = '0;
        forever begin
            @(negedge clk);
            if (!sram_we_n) begin
                dev_mem[sram_addr] = sram_wdata;
                we_cnt++;
                last_addr = sram_addr;
            end
            if (!sram_oe_n) begin
                sram_rdata = dev_mem.exists(sram_addr) ? dev_mem[sram_addr] : init_pat(sram_addr);
                oe_cnt++;
                last_addr = sram_addr;
            end else begin
                sram_rdata = '0;
            end
        end
    end

    // Reference model: each accepted request is a transaction starting at cycle
    // start_c and finishing (ready high) at end_c; SRAM strobes cover cycles 1..WC
    // of a non-hit transaction. Memory and the read buffer are updated at completion.
    logic [31:0] ref_mem [logic [AW-1:0]];

    function automatic logic [31:0] ref_read(input logic [AW-1:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : init_pat(w);
    endfunction

    initial begin : model_cmp
        int            end_c;
        int            start_c;
        logic          t_wr;
        logic          t_hit;
        logic          busy;
        logic          in_acc;
        logic          exp_ready;
        logic [AW-1:0] t_word;
        logic [31:0]   t_data;
        logic [31:0]   exp_rd;
        logic          bv;
        logic [AW-1:0] bw;
        logic [31:0]   bd;
        end_c   = -1;
        start_c = 0;
        t_wr    = 1'b0;
        t_hit   = 1'b0;
        t_word  = '0;
        t_data  = '0;
        exp_rd  = '0;
        bv      = 1'b0;
        bw      = '0;
        bd      = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                end_c  = -1;
                exp_rd = '0;
                bv     = 1'b0;
                chk("rst_we_n",   32'(sram_we_n), 32'd1);
                chk("rst_oe_n",   32'(sram_oe_n), 32'd1);
                chk("rst_rd_data", rd_data, 32'd0);
                chk("rst_sram_addr", 32'(sram_addr), 32'd0);
                chk("rst_sram_wdata", sram_wdata, 32'd0);
                chk("rst_ready", 32'(ready), 32'(!(mem_r_en || mem_w_en)));
            end else begin
                if ((cyc > end_c) && (mem_r_en || mem_w_en)) begin
                    start_c = cyc;
                    t_wr    = mem_w_en;
                    t_word  = word_of(address);
                    t_data  = wr_data;
                    t_hit   = BYP && !mem_w_en && bv && (bw == t_word);
                    end_c   = start_c + (t_hit ? 1 : int'(WC) + 1);
                end
                busy      = (cyc <= end_c);
                in_acc    = busy && !t_hit && (cyc - start_c >= 1) && (cyc - start_c <= int'(WC));
                exp_ready = busy ? (cyc == end_c) : 1'b1;
                if (busy && (cyc == end_c)) begin
                    if (t_wr) begin
                        ref_mem[t_word] = t_data;
                        if (bv && (bw == t_word)) bd = t_data;
                    end else begin
                        exp_rd = t_hit ? bd : ref_read(t_word);
                        bv     = 1'b1;
                        bw     = t_word;
                        bd     = exp_rd;
                    end
                end
                chk("ready",   32'(ready),     32'(exp_ready));
                chk("freeze",  32'(freeze),    32'(!exp_ready));
                chk("we_n",    32'(sram_we_n), 32'(!(in_acc && t_wr)));
                chk("oe_n",    32'(sram_oe_n), 32'(!(in_acc && !t_wr)));
                chk("rd_data", rd_data,        exp_rd);
                if (in_acc) begin
                    chk("sram_addr", 32'(sram_addr), 32'(t_word));
                    if (t_wr) chk("sram_wdata", sram_wdata, t_data);
                end
            end
        end
    end

    // One request held until ready; optional drop after drop_at cycles.
    // lat = cycle index (from request) in which ready is seen high.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int drop_at, output int lat);
        @(posedge clk);
        #1;
        mem_r_en = r;
        mem_w_en = w;
        address  = a;
        wr_data  = d;
        lat      = 0;
        forever begin
            @(negedge clk);
            if (ready) break;
            lat++;
            if (lat > 40) begin
                chk("ready_timeout", 32'(ready), 32'd1);
                break;
            end
            if ((drop_at > 0) && (lat == drop_at)) begin
                @(posedge clk);
                #1;
                mem_r_en = 1'b0;
                mem_w_en = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin : stim
        int   lat;
        int   we0;
        int   oe0;
        int   hi[$];
        int   exp_hi[$];
        int   sel;
        int   drop;
        int   gap;
        logic r;
        logic w;
        logic [31:0] a;

        // Reset and idle.
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_idle_ready", 32'(ready), 32'd1);

        // Store 0xDEADBEEF to 1032 (word 2).
        we0 = we_cnt;
        access(1'b0, 1'b1, BASE + 32'd8, 32'hDEAD_BEEF, 0, lat);
        chk("store_latency", lat, 32'd5);
        chk("store_we_cycles", we_cnt - we0, 32'd4);
        chk("store_sram_addr", 32'(last_addr), 32'd2);

        // Load it back.
        oe0 = oe_cnt;
        access(1'b1, 1'b0, BASE + 32'd8, 32'h0, 0, lat);
        chk("load_latency", lat, 32'd5);
        chk("load_oe_cycles", oe_cnt - oe0, 32'd4);
        chk("load_data", rd_data, 32'hDEAD_BEEF);

        // Both enables: the write wins.
        we0 = we_cnt;
        oe0 = oe_cnt;
        access(1'b1, 1'b1, 32'd1028, 32'hCAFE_F00D, 0, lat);
        chk("both_latency", lat, 32'd5);
        chk("both_we_cycles", we_cnt - we0, 32'd4);
        chk("both_oe_cycles", oe_cnt - oe0, 32'd0);
        chk("both_keeps_rd", rd_data, 32'hDEAD_BEEF);

        // Read held for 12 cycles: the cycle after DONE starts a new access.
        if (BYP) exp_hi = '{5, 7, 9, 11};
        else     exp_hi = '{5, 11};
        @(posedge clk);
        #1;
        mem_r_en = 1'b1;
        address  = 32'd1028;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ready) hi.push_back(i);
        end
        @(posedge clk);
        #1;
        mem_r_en = 1'b0;
        chk("b2b_count", 32'(hi.size()), 32'(exp_hi.size()));
        for (int i = 0; i < hi.size() && i < exp_hi.size(); i++) begin
            chk("b2b_ready_cycle", hi[i], exp_hi[i]);
        end
        chk("b2b_data", rd_data, 32'hCAFE_F00D);

        // Request dropped in cycle 2: the access still completes.
        access(1'b0, 1'b1, 32'd1036, 32'h0BAD_CAFE, 0, lat);
        access(1'b1, 1'b0, 32'd1036, 32'h0, 2, lat);
        chk("drop_latency", lat, 32'd5);
        chk("drop_data", rd_data, 32'h0BAD_CAFE);

        // Reset in the middle of a read access.
        @(posedge clk);
        #1;
        mem_r_en = 1'b1;
        address  = 32'd1032;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("midrst_we_n", 32'(sram_we_n), 32'd1);
        chk("midrst_rd_data", rd_data, 32'd0);
        mem_r_en = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(ready), 32'd1);

        // Repeat read of 1032 and write-then-read coherence.
        access(1'b1, 1'b0, 32'd1032, 32'h0, 0, lat);
        chk("rd1032_first_latency", lat, 32'd5);
        we0 = we_cnt;
        oe0 = oe_cnt;
        access(1'b1, 1'b0, 32'd1032, 32'h0, 0, lat);
        chk("rd1032_repeat_latency", lat, HIT_LAT);
        chk("rd1032_repeat_oe", oe_cnt - oe0, BYP ? 32'd0 : 32'd4);
        chk("rd1032_repeat_data", rd_data, 32'hDEAD_BEEF);
        access(1'b0, 1'b1, 32'd1032, 32'h1234_5678, 0, lat);
        access(1'b1, 1'b0, 32'd1032, 32'h0, 0, lat);
        chk("wr_rd1032_latency", lat, HIT_LAT);
        chk("wr_rd1032_data", rd_data, 32'h1234_5678);
        chk("wr_rd1032_we", we_cnt - we0, 32'd4);

        // Randomized request stream.
        for (int n = 0; n < 300; n++) begin
            sel  = int'($urandom_range(0, 9));
            r    = (sel < 5) || (sel == 9);
            w    = (sel >= 5);
            if ($urandom_range(0, 15) == 0) a = $urandom;
            else a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            gap  = int'($urandom_range(0, 2));
            repeat (gap) @(posedge clk);
            access(r, w, a, $urandom, drop, lat);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
